mem_arbiter_clear: RTL and testbench

//  Shares one single-ported, zero-wait 32-bit synchronous RAM (1-cycle registered read)

---
 rtl/mem_arbiter_clear_if.sv | 48 ++++
 rtl/mem_arbiter_clear.sv | 105 ++++++++++
 tb/tb_mem_arbiter_clear.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_clear_if.sv
// Bus bundle for mem_arbiter_clear: two requester ports and one RAM port.
// slave = arbiter view, master = requesters plus RAM view.
interface mem_arbiter_clear_if #(
  parameter int WIDTH = 13
);
  logic             a_valid;
  logic             a_ready;
  logic             a_write;
  logic [3:0]       a_wmask;
  logic [31:0]      a_wdata;
  logic [WIDTH-1:0] a_addr;
  logic             a_rvalid;
  logic [31:0]      a_rdata;

  logic             b_valid;
  logic             b_ready;
  logic             b_write;
  logic [3:0]       b_wmask;
  logic [31:0]      b_wdata;
  logic [WIDTH-1:0] b_addr;
  logic             b_rvalid;
  logic [31:0]      b_rdata;

  logic             mem_valid;
  logic             mem_write;
  logic [3:0]       mem_wmask;
  logic [31:0]      mem_wdata;
  logic [WIDTH-1:0] mem_addr;
  logic [31:0]      mem_rdata;

  modport slave (
    input  a_valid, a_write, a_wmask, a_wdata, a_addr,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_write, b_wmask, b_wdata, b_addr,
    output b_ready, b_rvalid, b_rdata,
    output mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    input  mem_rdata
  );

  modport master (
    output a_valid, a_write, a_wmask, a_wdata, a_addr,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_write, b_wmask, b_wdata, b_addr,
    input  b_ready, b_rvalid, b_rdata,
    input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_clear.sv
// Two-requester arbiter for a single-ported 1-cycle RAM.
// Zero-fills the RAM after reset, then alternates grants under contention.
module mem_arbiter_clear #(
  parameter int WIDTH = 13,
  parameter bit CLEAR = 1'b1
) (
  input  logic clk,
  input  logic rst,
  output logic busy,
  mem_arbiter_clear_if.slave bus
);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  localparam logic [WIDTH-1:0] LAST = '1;
  localparam state_t RST_STATE = CLEAR ? S_CLEAR : S_RUN;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             r_prio;
  logic             w_prio_nxt;
  logic             r_a_rvalid;
  logic             r_b_rvalid;
  logic             w_grant_a;
  logic             w_grant_b;

  // state, fill counter, priority and read-response flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RST_STATE;
      r_cnt      <= '0;
      r_prio     <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_prio     <= w_prio_nxt;
      r_a_rvalid <= w_grant_a & ~bus.a_write;
      r_b_rvalid <= w_grant_b & ~bus.b_write;
    end
  end

  // fill sequencing, grant selection and RAM port muxing
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_prio_nxt    = r_prio;
    w_grant_a     = 1'b0;
    w_grant_b     = 1'b0;
    busy          = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_wmask = 4'b0000;
    bus.mem_wdata = 32'h0;
    bus.mem_addr  = '0;
    unique case (r_state)
      S_CLEAR: begin
        busy          = 1'b1;
        bus.mem_valid = ~rst;
        bus.mem_write = 1'b1;
        bus.mem_wmask = 4'b1111;
        bus.mem_addr  = r_cnt;
        w_cnt_nxt     = r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_grant_a = ~rst & bus.a_valid
                  & (~bus.b_valid | ~r_prio);
        w_grant_b = ~rst & bus.b_valid
                  & (~bus.a_valid | r_prio);
        if (w_grant_a) begin
          bus.mem_valid = 1'b1;
          bus.mem_write = bus.a_write;
          bus.mem_wmask = bus.a_wmask;
          bus.mem_wdata = bus.a_wdata;
          bus.mem_addr  = bus.a_addr;
          w_prio_nxt    = 1'b1;
        end else if (w_grant_b) begin
          bus.mem_valid = 1'b1;
          bus.mem_write = bus.b_write;
          bus.mem_wmask = bus.b_wmask;
          bus.mem_wdata = bus.b_wdata;
          bus.mem_addr  = bus.b_addr;
          w_prio_nxt    = 1'b0;
        end
      end
    endcase
  end

  assign bus.a_ready  = w_grant_a;
  assign bus.b_ready  = w_grant_b;
  assign bus.a_rvalid = r_a_rvalid;
  assign bus.b_rvalid = r_b_rvalid;
  assign bus.a_rdata  = bus.mem_rdata;
  assign bus.b_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_clear.sv
// Bench for mem_arbiter_clear: vector table plus reset/fill sequences,
// with a behavioural RAM and a read-response scoreboard.
module tb_mem_arbiter_clear;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic busy;
  logic busy2;
  logic ram_init = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter_clear_if #(.WIDTH(4)) bus ();
  mem_arbiter_clear_if #(.WIDTH(4)) bus2 ();

  mem_arbiter_clear #(.WIDTH(4), .CLEAR(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .busy(busy),
    .bus (bus)
  );

  mem_arbiter_clear #(.WIDTH(4), .CLEAR(1'b0)) dut2 (
    .clk (clk),
    .rst (rst2),
    .busy(busy2),
    .bus (bus2)
  );

  logic [31:0] ram  [16];
  logic [31:0] ram2 [16];

  // RAM models, preloaded with junk so the fill is visible
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) begin
        ram[i]  <= 32'hDEAD0000 | i;
        ram2[i] <= 32'hDEAD0000 | i;
      end
    end else begin
      if (bus.mem_valid) begin
        if (bus.mem_write) begin
          for (int k = 0; k < 4; k++)
            if (bus.mem_wmask[k])
              ram[bus.mem_addr][8*k+:8] <= bus.mem_wdata[8*k+:8];
        end else begin
          bus.mem_rdata <= ram[bus.mem_addr];
        end
      end
      if (bus2.mem_valid) begin
        if (bus2.mem_write) begin
          for (int k = 0; k < 4; k++)
            if (bus2.mem_wmask[k])
              ram2[bus2.mem_addr][8*k+:8] <= bus2.mem_wdata[8*k+:8];
        end else begin
          bus2.mem_rdata <= ram2[bus2.mem_addr];
        end
      end
    end
  end

  typedef struct {
    string       name;
    logic        av;
    logic        aw;
    logic [3:0]  am;
    logic [31:0] ad;
    logic [3:0]  aa;
    logic        bv;
    logic        bw;
    logic [3:0]  bm;
    logic [31:0] bd;
    logic [3:0]  ba;
    logic        ea;
    logic        eb;
  } vec_t;

  typedef struct {
    logic        is_b;
    logic [31:0] data;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic [31:0] sh[16];
  vec_t        tbl[21];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  function automatic vec_t mkv(
    string nm,
    logic av, logic aw, logic [3:0] am, logic [31:0] ad, logic [3:0] aa,
    logic bv, logic bw, logic [3:0] bm, logic [31:0] bd, logic [3:0] ba,
    logic ea, logic eb);
    vec_t v;
    v.name = nm;
    v.av = av; v.aw = aw; v.am = am; v.ad = ad; v.aa = aa;
    v.bv = bv; v.bw = bw; v.bm = bm; v.bd = bd; v.ba = ba;
    v.ea = ea; v.eb = eb;
    return v;
  endfunction

  function automatic void sh_write(logic [3:0] a, logic [3:0] m,
                                   logic [31:0] d);
    for (int k = 0; k < 4; k++)
      if (m[k]) sh[a][8*k+:8] = d[8*k+:8];
  endfunction

  task automatic check_resp(string nm);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({nm, "_rv"}, {62'd0, bus.a_rvalid, bus.b_rvalid},
          {62'd0, ~e.is_b, e.is_b});
      if (e.is_b)
        chk({nm, "_bdata"}, {32'd0, bus.b_rdata}, {32'd0, e.data});
      else
        chk({nm, "_adata"}, {32'd0, bus.a_rdata}, {32'd0, e.data});
    end else begin
      chk({nm, "_norv"}, {62'd0, bus.a_rvalid, bus.b_rvalid}, 64'd0);
    end
  endtask

  // entered and left at a falling edge
  task automatic step(input vec_t v);
    exp_t e;
    bus.a_valid = v.av; bus.a_write = v.aw; bus.a_wmask = v.am;
    bus.a_wdata = v.ad; bus.a_addr = v.aa;
    bus.b_valid = v.bv; bus.b_write = v.bw; bus.b_wmask = v.bm;
    bus.b_wdata = v.bd; bus.b_addr = v.ba;
    #1;
    chk({v.name, "_grant"},
        {60'd0, bus.a_ready, bus.b_ready, bus.mem_valid, busy},
        {60'd0, v.ea, v.eb, v.ea | v.eb, 1'b0});
    if (v.ea) begin
      if (v.aw) sh_write(v.aa, v.am, v.ad);
      else begin e.is_b = 1'b0; e.data = sh[v.aa]; sb.push_back(e); end
    end else if (v.eb) begin
      if (v.bw) sh_write(v.ba, v.bm, v.bd);
      else begin e.is_b = 1'b1; e.data = sh[v.ba]; sb.push_back(e); end
    end
    @(posedge clk);
    #1;
    check_resp(v.name);
    @(negedge clk);
  endtask

  // entered at the falling edge where rst was just released
  task automatic check_fill(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk($sformatf("fill%0d", i),
          {17'd0, busy, bus.mem_valid, bus.mem_write, bus.mem_wmask,
           bus.mem_wdata, bus.mem_addr, bus.a_ready, bus.b_ready,
           bus.a_rvalid, bus.b_rvalid},
          {17'd0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, i[3:0], 4'b0000});
      @(negedge clk);
    end
    if (n == 16)
      for (int i = 0; i < 16; i++) sh[i] = 32'h0;
  endtask

  initial begin
    tbl[0]  = mkv("t1_first", 1,0,4'h0,32'h0,4'd0, 0,0,4'h0,32'h0,4'd0, 1,0);
    tbl[1]  = mkv("t2_awr5", 1,1,4'hF,32'h12345678,4'd5,
                  0,0,4'h0,32'h0,4'd0, 1,0);
    tbl[2]  = mkv("t2_ard5", 1,0,4'h0,32'h0,4'd5, 0,0,4'h0,32'h0,4'd0, 1,0);
    tbl[3]  = mkv("t3_bwr0", 0,0,4'h0,32'h0,4'd0,
                  1,1,4'b0010,32'h0000AB00,4'd0, 0,1);
    tbl[4]  = mkv("t3_brd0", 0,0,4'h0,32'h0,4'd0, 1,0,4'h0,32'h0,4'd0, 0,1);
    for (int i = 0; i < 6; i++)
      tbl[5+i] = mkv($sformatf("t4_cont%0d", i),
                     1,0,4'h0,32'h0,4'd5, 1,0,4'h0,32'h0,4'd0,
                     (i % 2) == 0, (i % 2) == 1);
    tbl[11] = mkv("idle", 0,0,4'h0,32'h0,4'd0, 0,0,4'h0,32'h0,4'd0, 0,0);
    tbl[12] = mkv("ord_a", 1,0,4'h0,32'h0,4'd5,
                  1,1,4'hF,32'hCAFEF00D,4'd5, 1,0);
    tbl[13] = mkv("ord_b", 1,0,4'h0,32'h0,4'd5,
                  1,1,4'hF,32'hCAFEF00D,4'd5, 0,1);
    tbl[14] = mkv("ord_a2", 1,0,4'h0,32'h0,4'd5, 0,0,4'h0,32'h0,4'd0, 1,0);
    tbl[15] = mkv("a_mask", 1,1,4'b1001,32'hAABBCCDD,4'd7,
                  0,0,4'h0,32'h0,4'd0, 1,0);
    tbl[16] = mkv("a_rd7", 1,0,4'h0,32'h0,4'd7, 0,0,4'h0,32'h0,4'd0, 1,0);
    tbl[17] = mkv("b_rd15", 0,0,4'h0,32'h0,4'd0, 1,0,4'h0,32'h0,4'd15, 0,1);
    tbl[18] = mkv("b_rd9", 0,0,4'h0,32'h0,4'd0, 1,0,4'h0,32'h0,4'd9, 0,1);
    tbl[19] = mkv("b_wr15", 0,0,4'h0,32'h0,4'd0,
                  1,1,4'hF,32'h11112222,4'd15, 0,1);
    tbl[20] = mkv("a_rd15", 1,0,4'h0,32'h0,4'd15, 0,0,4'h0,32'h0,4'd0, 1,0);

    for (int i = 0; i < 16; i++) sh[i] = 32'hX;
    bus.a_valid = 1'b1; bus.a_write = 1'b0; bus.a_wmask = 4'h0;
    bus.a_wdata = 32'h0; bus.a_addr = 4'd0;
    bus.b_valid = 1'b0; bus.b_write = 1'b0; bus.b_wmask = 4'h0;
    bus.b_wdata = 32'h0; bus.b_addr = 4'd0;
    bus2.a_valid = 1'b1; bus2.a_write = 1'b0; bus2.a_wmask = 4'h0;
    bus2.a_wdata = 32'h0; bus2.a_addr = 4'd3;
    bus2.b_valid = 1'b0; bus2.b_write = 1'b0; bus2.b_wmask = 4'h0;
    bus2.b_wdata = 32'h0; bus2.b_addr = 4'd0;

    // held in reset with A requesting
    repeat (3) @(negedge clk);
    ram_init = 1'b0;
    #1;
    chk("rst_state", {60'd0, busy, bus.a_ready, bus.a_rvalid, bus.mem_valid},
        {60'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    check_fill(16);

    // vector table, first entry is the post-fill grant
    for (int i = 0; i < 21; i++) step(tbl[i]);

    // reset while a read response is pending
    bus.a_valid = 1'b1; bus.a_write = 1'b0; bus.a_addr = 4'd5;
    bus.b_valid = 1'b0;
    #1;
    chk("prs_grant", {63'd0, bus.a_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("prs_rv", {63'd0, bus.a_rvalid}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop", {60'd0, bus.a_rvalid, bus.b_rvalid, bus.a_ready, busy},
        {60'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_fill(16);
    step(mkv("post_rst", 1,0,4'h0,32'h0,4'd5, 0,0,4'h0,32'h0,4'd0, 1,0));

    // reset in the middle of the fill
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_fill(7);
    #1;
    chk("mid_addr", {60'd0, bus.mem_addr}, 64'd7);
    rst = 1'b1;
    #1;
    chk("mid_rst", {61'd0, bus.mem_valid, bus.a_ready, busy},
        {61'd0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_fill(16);
    step(mkv("refill", 1,0,4'h0,32'h0,4'd0, 0,0,4'h0,32'h0,4'd0, 1,0));

    // no-clear instance: immediate service after reset
    #1;
    chk("nc_rst", {61'd0, bus2.a_ready, busy2, bus2.a_rvalid}, 64'd0);
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    chk("nc_grant", {60'd0, bus2.a_ready, bus2.b_ready, busy2, bus2.mem_valid},
        {60'd0, 1'b1, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    chk("nc_rv", {62'd0, bus2.a_rvalid, bus2.b_rvalid}, {62'd0, 2'b10});
    chk("nc_data", {32'd0, bus2.a_rdata}, {32'd0, 32'hDEAD0003});
    chk("nc_busy", {63'd0, busy2}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
